// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// The optional inter-frame gap is compiled in with UART_TX_ARB_GAP_EN.
package uart_tx_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_GAP_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // Index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_WIDTH = idx_width(DEF_NUM_REQ);

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping around to bit 0.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX path between NUM_REQ byte requesters, one frame at a time.
// Define UART_TX_ARB_GAP_EN to add GAP_CYCLES of forced idle after each frame.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
  localparam int IDW        = idx_width(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_parity_en,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_valid,
  output logic                          tx_parity_enable,
  output logic [IDW-1:0]                grant_id,
  output logic                          arb_busy,
  output logic [2:0]                    dbg_state
);

  // Handshake: a requester holds req_valid with stable data until it sees its
  // one-cycle req_ready pulse; tx_data_valid pulses once per frame and the
  // frame is considered finished when tx_busy has risen and then fallen.

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef UART_TX_ARB_GAP_EN
  localparam int GW       = idx_width(GAP_CYCLES);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  logic [GW-1:0] gap_cnt_q;
`else
  // GAP_CYCLES is only consumed by the gap build; this guard keeps it referenced.
  if (GAP_CYCLES < 0) begin : g_gap_cycles_negative
  end
`endif

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An externally started frame keeps the line owned; wait it out.
        if (!tx_busy && pick_found) begin
          grant   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:      state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_ARB_GAP_EN
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef UART_TX_ARB_GAP_EN
      ST_GAP:       if (gap_cnt_q == '0) state_d = ST_IDLE;
`endif
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= '0;
      req_ready        <= '0;
      tx_data          <= '0;
      tx_data_valid    <= 1'b0;
      tx_parity_enable <= 1'b0;
      grant_id         <= '0;
      arb_busy         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_valid <= grant;
      req_ready     <= grant ? (NUM_REQ'(1) << pick_idx) : '0;
      arb_busy      <= (state_d != ST_IDLE);
      if (grant) begin
        tx_data          <= req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        tx_parity_enable <= req_parity_en[pick_idx];
        grant_id         <= pick_idx;
      end
      if (state_q == ST_LOAD) begin
        rr_ptr_q <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

`ifdef UART_TX_ARB_GAP_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gap_cnt_q <= '0;
    end else if (state_q == ST_WAIT_DONE && state_d == ST_GAP) begin
      gap_cnt_q <= GW'(GAP_LOAD);
    end else if (state_q == ST_GAP && gap_cnt_q != '0) begin
      gap_cnt_q <= gap_cnt_q - GW'(1);
    end
  end
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps followed by
// randomized request traffic checked against a round-robin reference model.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 11;
`ifdef UART_TX_ARB_GAP_EN
  localparam int G = 5;
`else
  localparam int G = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_parity_en = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          tx_busy_man = 1'b0;
  logic          tx_busy_auto = 1'b0;
  logic          tx_busy;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid;
  logic          tx_parity_enable;
  logic [1:0]    grant_id;
  logic          arb_busy;
  logic [2:0]    dbg_state;

  bit tx_auto = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_ptr = 0;
  int last_pulse = -1;
  int waited[N];

  assign tx_busy = tx_busy_man | tx_busy_auto;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .GAP_CYCLES (5)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_parity_en    (req_parity_en),
    .req_ready        (req_ready),
    .tx_busy          (tx_busy),
    .tx_data          (tx_data),
    .tx_data_valid    (tx_data_valid),
    .tx_parity_enable (tx_parity_enable),
    .grant_id         (grant_id),
    .arb_busy         (arb_busy),
    .dbg_state        (dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  // TX path model: Busy rises the cycle after Data_Valid is seen, lasts L cycles.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (tx_auto && tx_data_valid) begin
        @(posedge CLK); #1;
        tx_busy_auto = 1'b1;
        repeat (L) @(posedge CLK);
        #1 tx_busy_auto = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first pending requester at or after ptr, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Called on the LOAD cycle with requests already dropped.
  task automatic finish_frame(input int len);
    tick;
    chk("wait_busy_no_pulse", tx_data_valid, 0);
    tx_busy_man = 1'b1;
    repeat (len) begin
      tick;
      chk("busy_no_pulse", tx_data_valid, 0);
      chk("busy_arb_busy", arb_busy, 1);
    end
    tx_busy_man = 1'b0;
    for (int k = 0; k < G; k++) begin
      tick;
      chk("gap_arb_busy", arb_busy, 1);
    end
    tick;
    chk("idle_after_frame", arb_busy, 0);
  endtask

  task automatic run_phase(input int cycles, input int raise_pct, input int keep_pct, input bit exact);
    int w;
    for (int c = 0; c < cycles; c++) begin
      tick;
      if (tx_data_valid) begin
        w = pick(req_valid, exp_ptr);
        chk("grant_had_request", (w >= 0), 1);
        if (w < 0) w = 0;
        chk("grant_id", grant_id, w);
        chk("req_ready", req_ready, 32'(1) << w);
        chk("tx_data", tx_data, req_data[w*DW +: DW]);
        chk("tx_parity", tx_parity_enable, req_parity_en[w]);
        chk("fairness", (waited[w] <= N - 1), 1);
        if (last_pulse >= 0) begin
          if (exact) chk("spacing", cyc - last_pulse, L + 3 + G);
          else       chk("spacing_min", ((cyc - last_pulse) >= L + 3 + G), 1);
        end
        for (int j = 0; j < N; j++)
          if (j != w && req_valid[j]) waited[j]++;
        waited[w] = 0;
        last_pulse = cyc;
        exp_ptr = (w + 1) % N;
        if ($urandom_range(0, 99) >= keep_pct) req_valid[w] = 1'b0;
      end else begin
        chk("no_ready", req_ready, 0);
      end
      for (int j = 0; j < N; j++) begin
        if (!req_valid[j] && $urandom_range(0, 99) < raise_pct) begin
          req_valid[j] = 1'b1;
          req_data[j*DW +: DW] = DW'($urandom);
          req_parity_en[j] = 1'($urandom_range(0, 1));
          waited[j] = 0;
        end
      end
    end
  endtask

  initial begin
    foreach (waited[i]) waited[i] = 0;

    // Reset values
    #2 RST = 1'b0;
    tick; tick;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_data_valid", tx_data_valid, 0);
    chk("rst_tx_parity", tx_parity_enable, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    RST = 1'b1;
    tick;

    // Single request from requester 2
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    req_parity_en[2] = 1'b1;
    tick;
    chk("single_valid", tx_data_valid, 1);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_data", tx_data, 8'hA5);
    chk("single_parity", tx_parity_enable, 1);
    chk("single_gid", grant_id, 2);
    chk("single_arb_busy", arb_busy, 1);
    req_valid = '0;
    finish_frame(5);
    chk("hold_data", tx_data, 8'hA5);
    chk("hold_gid", grant_id, 2);

    // Wrap and skip: pointer at 3, requesters 0 and 1 pending
    req_valid = 4'b0011;
    req_data[7:0] = 8'h11;  req_parity_en[0] = 1'b0;
    req_data[15:8] = 8'h22; req_parity_en[1] = 1'b1;
    tick;
    chk("wrap_gid", grant_id, 0);
    chk("wrap_ready", req_ready, 4'b0001);
    chk("wrap_data", tx_data, 8'h11);
    chk("wrap_parity", tx_parity_enable, 0);
    req_valid[0] = 1'b0;
    finish_frame(4);
    tick;
    chk("after_wrap_valid", tx_data_valid, 1);
    chk("after_wrap_gid", grant_id, 1);
    chk("after_wrap_ready", req_ready, 4'b0010);
    chk("after_wrap_data", tx_data, 8'h22);
    req_valid = '0;
    finish_frame(3);

    // Withdrawal while an external frame holds the line
    tx_busy_man = 1'b1;
    req_valid = 4'b0100;
    req_data[23:16] = 8'h5A;
    repeat (3) begin
      tick;
      chk("ext_busy_no_pulse", tx_data_valid, 0);
      chk("ext_busy_arb_idle", arb_busy, 0);
    end
    req_valid = '0;
    tick;
    tx_busy_man = 1'b0;
    repeat (3) begin
      tick;
      chk("withdrawn_no_pulse", tx_data_valid, 0);
      chk("withdrawn_no_ready", req_ready, 0);
    end
    chk("withdrawn_hold_data", tx_data, 8'h22);

    // Reset in the middle of a frame
    req_valid = 4'b0010;
    req_data[15:8] = 8'h3C;
    req_parity_en[1] = 1'b1;
    tick;
    chk("pre_rst_gid", grant_id, 1);
    chk("pre_rst_valid", tx_data_valid, 1);
    req_valid = '0;
    tick;
    tx_busy_man = 1'b1;
    tick; tick;
    chk("pre_rst_wait_done", dbg_state, ST_WAIT_DONE);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_state", dbg_state, ST_IDLE);
    chk("mid_rst_arb_busy", arb_busy, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_parity", tx_parity_enable, 0);
    chk("mid_rst_gid", grant_id, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_valid", tx_data_valid, 0);
    tick;
    RST = 1'b1;
    tx_busy_man = 1'b0;
    tx_auto = 1'b1;
    exp_ptr = 0;
    for (int j = 0; j < N; j++) begin
      req_data[j*DW +: DW] = DW'($urandom);
      req_parity_en[j] = 1'($urandom_range(0, 1));
    end
    req_valid = 4'b1111;
    tick;
    chk("post_rst_valid", tx_data_valid, 1);
    chk("post_rst_gid", grant_id, 0);
    chk("post_rst_ready", req_ready, 4'b0001);
    chk("post_rst_data", tx_data, req_data[7:0]);
    last_pulse = cyc;
    exp_ptr = 1;
    for (int j = 1; j < N; j++) waited[j] = 1;

    // All requesters continuously valid: strict rotation at minimum spacing
    run_phase(4 * (L + 3 + G) + 2, 100, 100, 1'b1);
    // Random traffic
    run_phase(800, 20, 25, 1'b0);
    // Drain
    run_phase(300, 0, 0, 1'b0);
    chk("drained", req_valid, 0);
    for (int k = 0; k < 100 && (arb_busy || tx_busy); k++) tick;
    chk("final_idle", arb_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (the `fsm_uart_tx`-based TX path) between `NUM_REQ` byte requesters. It selects one pending requester and latches its byte and parity setting. It then pulses `Data_Valid` into the TX path and tracks the TX `Busy` output until the frame completes. Only then does it serve the next requester. It sits between the client blocks and the UART TX top.

## Interface

Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 8, byte width forwarded to the TX path
- `GAP_CYCLES`, 16, idle cycles inserted between frames; used only with `UART_TX_ARB_GAP_EN`

Ports:
- `CLK`  in  1  system clock, rising-edge
- `RST`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester request; held until `req_ready`
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`; stable while `req_valid`
- `req_parity_en`  in  NUM_REQ  per-requester parity enable; stable while `req_valid`
- `req_ready`  out  NUM_REQ  one-hot, one-cycle acceptance pulse
- `tx_busy`  in  1  `Busy` from the UART TX path
- `tx_data`  out  DATA_WIDTH  byte to the TX path, held for the whole frame
- `tx_data_valid`  out  1  one-cycle `Data_Valid` pulse
- `tx_parity_enable`  out  1  `parity_enable` to the TX path, held for the whole frame
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester
- `arb_busy`  out  1  high whenever the state is not IDLE

## Operation

- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, and GAP (GAP exists only with the macro).
- **IDLE:**
  - Arbitrates only when `tx_busy`=0 and `|req_valid`.
  - Winner is the first set `req_valid` bit, searching upward from `rr_ptr` with wrap-around.
  - On that edge, latches `tx_data`, `tx_parity_enable` and `grant_id` from the winner, then goes to LOAD.
- **LOAD:** lasts one cycle.
  - `tx_data_valid`=1 and `req_ready[grant_id]`=1.
  - `rr_ptr` is set to `grant_id+1`, wrapping to 0 after `NUM_REQ-1`.
  - Goes to WAIT_BUSY.
- **WAIT_BUSY:** goes to WAIT_DONE when `tx_busy`=1. It does not re-pulse `tx_data_valid`.
- **WAIT_DONE:** on `tx_busy`=0, goes to GAP (macro on) or IDLE (macro off).
- **GAP:** counter runs from `GAP_CYCLES-1` down to 0, then goes to IDLE. If `GAP_CYCLES`=0, GAP is skipped.
- A requester that drops `req_valid` before it is granted is simply not selected. No error is raised.
- A requester whose `req_valid` is still high after its `req_ready` pulse is treated as a new request and competes normally.
- If `tx_busy`=1 while in IDLE (e.g. the TX path was started externally), no grant is made until it falls.
- `tx_data`, `tx_parity_enable` and `grant_id` hold their value through IDLE until the next grant.

## Timing

- Reset (`RST`=0, async) values:
  - state = IDLE, `rr_ptr`=0, gap counter = 0.
  - Outputs: `req_ready`=0, `tx_data`=0, `tx_data_valid`=0, `tx_parity_enable`=0, `grant_id`=0, `arb_busy`=0.
- Reset asserted mid-frame aborts immediately to IDLE. It does not wait for `tx_busy`.
- All outputs are registered. There are no combinational input-to-output paths.
- Latency:
  - `req_valid` sampled high in IDLE gives `tx_data_valid`/`req_ready` on the next cycle.
  - Minimum spacing between consecutive `tx_data_valid` pulses = frame `Busy` length + 3 cycles (+ `GAP_CYCLES` with the macro on).
- Fairness: with all requesters continuously valid, grants occur in order `rr_ptr`, `rr_ptr+1`, …, with wrap-around.
- Every requester is served within `NUM_REQ` grants.

## Configuration

- Macro: `UART_TX_ARB_GAP_EN`.
- Defined: GAP state is compiled in. After every frame, `arb_busy` stays high for `GAP_CYCLES` extra cycles before the next grant (guaranteed line idle time).
- Undefined: no GAP state and no counter. WAIT_DONE returns directly to IDLE, and `GAP_CYCLES` is ignored.

## Structure

- Package `uart_tx_arb_pkg` holds:
  - the state enum (IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP)
  - default parameter constants
  - a `clog2`-based width constant for `grant_id`/`rr_ptr`
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `found` and winner index.
  - Instantiated once.

## Test plan

- Reset mid-frame: grant requester 1, assert `RST`=0 while `tx_busy`=1 → all outputs 0 and state IDLE at once. After release, `rr_ptr`=0 and requester 0 wins first.
- Single request: `req_valid`=4'b0100, data 8'hA5, parity_en=1 → next cycle `tx_data_valid`=1, `req_ready`=4'b0100, `tx_data`=8'hA5, `tx_parity_enable`=1, `grant_id`=2. No further pulse until `tx_busy` goes 1→0.
- Round-robin: all four valid continuously, `tx_busy` modelled as 11 cycles per frame → grants in order 0,1,2,3,0, one `tx_data_valid` per frame.
- Wrap and skip: `rr_ptr`=3, `req_valid`=4'b0011 → requester 0 wins, then `rr_ptr`=1.
- Withdrawal and external busy: requester 2 drops `req_valid` while `tx_busy`=1 in IDLE → no grant. When busy falls with `req_valid`=0, there is no `tx_data_valid`.
- Gap (macro on, `GAP_CYCLES`=5): back-to-back requests → `arb_busy` stays high 5 cycles after `tx_busy` falls. The next `tx_data_valid` follows 2 cycles later.
